// File: rtl/dl_pwm_pkg.sv
// Shared types for the dl_pwm_gen PWM generator.
//   pwm_state_t : controller state (idle, generating, finishing last period)
//   PWM_STATE_W : encoded state width
package dl_pwm_pkg;

    localparam int PWM_STATE_W = 2;

    typedef enum logic [PWM_STATE_W-1:0] {
        PWM_IDLE,
        PWM_RUN,
        PWM_STOP
    } pwm_state_t;

endpackage

// File: rtl/dl_pwm_shadow.sv
// Pending/active configuration register pair for dl_pwm_gen.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   idle              : controller is in IDLE (accepted config loads active directly)
//   boundary          : period boundary this cycle (pending config becomes active)
//   cfg_valid/ready   : config handshake; ready while no config is pending
//   cfg_period/duty   : offered config values
//   active_period/duty: config governing the current period
//   duty_next         : value active_duty takes at the coming edge
module dl_pwm_shadow #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                idle,
    input  logic                boundary,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [NUM_BITS-1:0] cfg_period,
    input  logic [NUM_BITS-1:0] cfg_duty,
    output logic [NUM_BITS-1:0] active_period,
    output logic [NUM_BITS-1:0] active_duty,
    output logic [NUM_BITS-1:0] duty_next
);

    logic                pending_valid;
    logic [NUM_BITS-1:0] pending_period;
    logic [NUM_BITS-1:0] pending_duty;

    logic                accept;
    logic                pending_valid_n;
    logic [NUM_BITS-1:0] pending_period_n;
    logic [NUM_BITS-1:0] pending_duty_n;
    logic [NUM_BITS-1:0] period_next;

    assign cfg_ready = !pending_valid;
    assign accept    = cfg_valid && cfg_ready;

    // accept requires pending_valid=0, so an accept and a pending apply
    // can never coincide; an accept on a boundary edge just waits a period.
    always_comb begin
        pending_valid_n  = pending_valid;
        pending_period_n = pending_period;
        pending_duty_n   = pending_duty;
        period_next      = active_period;
        duty_next        = active_duty;
        if (idle) begin
            if (accept) begin
                period_next = cfg_period;
                duty_next   = cfg_duty;
            end
        end else begin
            if (boundary && pending_valid) begin
                period_next     = pending_period;
                duty_next       = pending_duty;
                pending_valid_n = 1'b0;
            end
            if (accept) begin
                pending_period_n = cfg_period;
                pending_duty_n   = cfg_duty;
                pending_valid_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_valid  <= 1'b0;
            pending_period <= '0;
            pending_duty   <= '0;
            active_period  <= '0;
            active_duty    <= '0;
        end else begin
            pending_valid  <= pending_valid_n;
            pending_period <= pending_period_n;
            pending_duty   <= pending_duty_n;
            active_period  <= period_next;
            active_duty    <= duty_next;
        end
    end

endmodule

// File: rtl/dl_pwm_gen.sv
// Programmable PWM generator driven by a prescaler tick.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   tick_en         : one-cycle count enable from the prescaler
//   run             : 1 = generate, 0 = stop at the next period boundary
//   cfg_valid/ready : config handshake (period/duty), applied at boundaries
//   cfg_period      : terminal count, period = cfg_period+1 ticks
//   cfg_duty        : high ticks per period
//   pwm_out         : registered PWM output
//   period_done     : one-cycle pulse after each boundary edge
//   cnt             : current period count
module dl_pwm_gen
    import dl_pwm_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_en,
    input  logic                run,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [NUM_BITS-1:0] cfg_period,
    input  logic [NUM_BITS-1:0] cfg_duty,
    output logic                pwm_out,
    output logic                period_done,
    output logic [NUM_BITS-1:0] cnt
);

    pwm_state_t          state;
    pwm_state_t          state_n;
    logic [NUM_BITS-1:0] cnt_n;
    logic                boundary;
    logic                pwm_n;
    logic [NUM_BITS-1:0] active_period;
    logic [NUM_BITS-1:0] active_duty;
    logic [NUM_BITS-1:0] duty_next;

    assign boundary = (state != PWM_IDLE) && tick_en && (cnt == active_period);

    dl_pwm_shadow #(
        .NUM_BITS(NUM_BITS)
    ) u_shadow (
        .clk          (clk),
        .rst          (rst),
        .idle         (state == PWM_IDLE),
        .boundary     (boundary),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .active_period(active_period),
        .active_duty  (active_duty),
        .duty_next    (duty_next)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            PWM_IDLE: begin
                cnt_n = '0;
                if (run) state_n = PWM_RUN;
            end
            PWM_RUN, PWM_STOP: begin
                if (tick_en) cnt_n = boundary ? '0 : cnt + NUM_BITS'(1);
                if (state == PWM_RUN) begin
                    if (!run) state_n = boundary ? PWM_IDLE : PWM_STOP;
                end else begin
                    if (boundary)  state_n = PWM_IDLE;
                    else if (run)  state_n = PWM_RUN;
                end
            end
            default: begin
                state_n = PWM_IDLE;
                cnt_n   = '0;
            end
        endcase
        // Compare against post-edge values so pwm_out has no extra lag.
        pwm_n = (state_n != PWM_IDLE) && (cnt_n < duty_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PWM_IDLE;
            cnt         <= '0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pwm_out     <= pwm_n;
            period_done <= boundary;
        end
    end

endmodule

// File: tb/tb_dl_pwm_gen.sv
module tb_dl_pwm_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_en = 1'b0;
    logic       run = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_duty = '0;
    logic       pwm_out;
    logic       period_done;
    logic [7:0] cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    dl_pwm_gen #(.NUM_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_en    (tick_en),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .cnt        (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs are set before calling; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input int c, input int p, input int d);
        check({tag, ".cnt"}, int'(cnt), c);
        check({tag, ".pwm"}, int'(pwm_out), p);
        check({tag, ".done"}, int'(period_done), d);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; tick_en = 1'b0; cfg_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic cfg_in_idle(input int p, input int d);
        cfg_valid = 1'b1; cfg_period = 8'(p); cfg_duty = 8'(d);
        step();
        cfg_valid = 1'b0;
        check("idle_cfg_ready", int'(cfg_ready), 1);
    endtask

    initial begin
        // Reset state
        do_reset();
        expect3("rst", 0, 0, 0);
        check("rst_ready", int'(cfg_ready), 1);

        // Reset mid-period, also mid-handshake
        cfg_in_idle(4, 2);
        run = 1'b1; tick_en = 1'b1;
        step(); expect3("rm0", 0, 1, 0);
        step(); expect3("rm1", 1, 1, 0);
        step(); expect3("rm2", 2, 0, 0);
        step(); expect3("rm3", 3, 0, 0);
        rst = 1'b1; cfg_valid = 1'b1; cfg_period = 8'd7; cfg_duty = 8'd7;
        step();
        rst = 1'b0; cfg_valid = 1'b0;
        expect3("rm_rst", 0, 0, 0);
        check("rm_rst_ready", int'(cfg_ready), 1);
        // Config was discarded: active period=0 duty=0 -> low, boundary every tick
        step(); expect3("rm_z0", 0, 0, 0);
        step(); expect3("rm_z1", 0, 0, 1);
        step(); expect3("rm_z2", 0, 0, 1);

        // Basic waveform period=4 duty=2
        do_reset();
        cfg_in_idle(4, 2);
        run = 1'b1; tick_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            expect3($sformatf("basic%0d", i), i % 5, (i % 5) < 2 ? 1 : 0,
                    (i > 0 && i % 5 == 0) ? 1 : 0);
        end
        // cnt=0 now; advance to cnt=2 then drop run
        step(); expect3("s1", 1, 1, 0);
        step(); expect3("s2", 2, 0, 0);
        run = 1'b0;
        step(); expect3("s3", 3, 0, 0);
        step(); expect3("s4", 4, 0, 0);
        step(); expect3("s_end", 0, 0, 1);
        step(); expect3("s_idle", 0, 0, 0);
        step(); expect3("s_idle2", 0, 0, 0);

        // Stop/resume without a break
        run = 1'b1;
        step(); expect3("r0", 0, 1, 0);
        step(); expect3("r1", 1, 1, 0);
        run = 1'b0;
        step(); expect3("r2", 2, 0, 0);
        step(); expect3("r3", 3, 0, 0);
        run = 1'b1;
        step(); expect3("r4", 4, 0, 0);
        step(); expect3("r5", 0, 1, 1);
        step(); expect3("r6", 1, 1, 0);

        // Shadow update at cnt=1: period=2 duty=3
        cfg_valid = 1'b1; cfg_period = 8'd2; cfg_duty = 8'd3;
        step();
        cfg_valid = 1'b0; cfg_period = 8'd0; cfg_duty = 8'd0;
        expect3("sh2", 2, 0, 0);
        check("sh_ready_lo", int'(cfg_ready), 0);
        step(); expect3("sh3", 3, 0, 0);
        step(); expect3("sh4", 4, 0, 0);
        check("sh_ready_still_lo", int'(cfg_ready), 0);
        step(); expect3("sh_b", 0, 1, 1);
        check("sh_ready_hi", int'(cfg_ready), 1);
        step(); expect3("sh_n1", 1, 1, 0);
        step(); expect3("sh_n2", 2, 1, 0);
        step(); expect3("sh_n3", 0, 1, 1);
        step(); expect3("sh_n4", 1, 1, 0);

        // Tick gating: tick every 3rd cycle, period=1 duty=1
        do_reset();
        cfg_in_idle(1, 1);
        run = 1'b1; tick_en = 1'b0;
        step(); expect3("tg_start", 0, 1, 0);
        for (int j = 0; j < 12; j++) begin
            tick_en = (j % 3 == 2);
            step();
            expect3($sformatf("tg%0d", j), ((j + 1) / 3) % 2,
                    (((j + 1) / 3) % 2 == 0) ? 1 : 0,
                    (j % 3 == 2 && ((j + 1) / 3) % 2 == 0) ? 1 : 0);
        end

        // duty=0 -> constant low
        do_reset();
        cfg_in_idle(4, 0);
        run = 1'b1; tick_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("d0_pwm%0d", i), int'(pwm_out), 0);
        end
        check("d0_cnt", int'(cnt), 1);

        // period=0 duty=1 -> constant high, done every tick
        do_reset();
        cfg_in_idle(0, 1);
        run = 1'b1; tick_en = 1'b1;
        step(); expect3("p0_s", 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(); expect3($sformatf("p0_%0d", i), 0, 1, 1);
        end

        // Config offered on the boundary edge applies one period later
        do_reset();
        cfg_in_idle(2, 1);
        run = 1'b1; tick_en = 1'b1;
        step(); expect3("bd0", 0, 1, 0);
        step(); expect3("bd1", 1, 0, 0);
        step(); expect3("bd2", 2, 0, 0);
        cfg_valid = 1'b1; cfg_period = 8'd4; cfg_duty = 8'd4;
        step();
        cfg_valid = 1'b0;
        expect3("bd_b0", 0, 1, 1);
        check("bd_ready", int'(cfg_ready), 0);
        step(); expect3("bd_b1", 1, 0, 0);
        step(); expect3("bd_b2", 2, 0, 0);
        step(); expect3("bd_ap0", 0, 1, 1);
        check("bd_ready_hi", int'(cfg_ready), 1);
        step(); expect3("bd_ap1", 1, 1, 0);
        step(); expect3("bd_ap2", 2, 1, 0);
        step(); expect3("bd_ap3", 3, 1, 0);
        step(); expect3("bd_ap4", 4, 0, 0);
        step(); expect3("bd_ap5", 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dl_pwm_gen.md
Name: dl_pwm_gen

Overview:
- Programmable PWM generator that sits directly downstream of the design_lib prescaler counter.
- Consumes the prescaler's one-cycle `done` pulse as `tick_en` and advances an internal period counter once per tick.
- Drives a PWM waveform with runtime period/duty reconfiguration over a valid/ready config port.
- Config updates are shadowed and applied only at period boundaries, so the output never shows a truncated or glitched period.

Parameters:
NUM_BITS, 8, width of period counter, period and duty values

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
tick_en  input  1  count enable; one-cycle pulse from upstream prescaler
run  input  1  level; 1 = generate PWM, 0 = stop at next period boundary
cfg_valid  input  1  new config offered
cfg_ready  output  1  block can accept config this cycle
cfg_period  input  NUM_BITS  terminal count; period = cfg_period+1 ticks
cfg_duty  input  NUM_BITS  high ticks per period
pwm_out  output  1  registered PWM output
period_done  output  1  registered one-cycle pulse at each period boundary
cnt  output  NUM_BITS  current period count (debug/observe)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; cnt, active_period, active_duty, pending regs = 0.
  - pending_valid=0, pwm_out=0, period_done=0, cfg_ready=1.
  - rst overrides all other inputs, including mid-period and mid-handshake; any pending config is discarded.
- Handshake:
  - Accept occurs when cfg_valid && cfg_ready; `cfg_ready = !pending_valid`.
  - In IDLE, an accepted config loads active_period/active_duty directly on that edge; pending_valid stays 0.
  - In RUN or STOP, an accepted config loads the pending regs and sets pending_valid=1.
  - The inputs need not be held after accept.
- Boundary event: `boundary = (state!=IDLE) && tick_en && (cnt==active_period)`.
- States:
  - IDLE:
    - cnt held at 0, pwm_out=0, tick_en ignored.
    - Go to RUN when run=1; cnt=0 on entry.
  - RUN:
    - On tick_en: `cnt <= boundary ? 0 : cnt+1`. Without tick_en, cnt holds.
    - On boundary with run=0: go to IDLE.
    - run=0 with no boundary: go to STOP.
  - STOP:
    - Identical counting to RUN, so the current period finishes.
    - On boundary go to IDLE.
    - run=1 before the boundary returns to RUN with no disturbance to cnt.
- Shadow apply:
  - On boundary with pending_valid=1: active_* <= pending_*, pending_valid <= 0.
  - The new values govern the period starting at cnt=0.
  - A config accepted on the same edge as a boundary is not applied at that boundary; it applies at the next one.
- pwm_out:
  - Registered. Each cycle `pwm_out == (state!=IDLE) && (cnt < active_duty)`, evaluated on the post-edge register values, so there is no extra cycle of lag.
  - duty=0 gives constant 0.
  - duty>active_period gives constant 1 while running.
  - active_period=0 gives a period of 1 tick; every tick is a boundary.
- period_done: 1 for exactly one cycle, the cycle after each boundary edge, including the final boundary into IDLE.
- Arithmetic: unsigned NUM_BITS. The cnt increment never exceeds active_period, so there is no wrap.

Decomposition:
- Package dl_pwm_pkg holds:
  - typedef enum logic [1:0] {PWM_IDLE, PWM_RUN, PWM_STOP} pwm_state_t
  - localparam PWM_STATE_W = 2
- One natural sub-module, dl_pwm_shadow: pending/active register pair with the handshake, apply-on-boundary and direct-load-in-IDLE logic.
- The FSM, counter and compare stay in the top module.

Test Plan:
- Reset mid-period: run at period=4, duty=2, tick_en=1 continuously; assert rst at cnt=3 -> next cycle cnt=0, pwm_out=0, state IDLE, cfg_ready=1, period_done=0.
- Basic waveform: cfg period=4, duty=2 in IDLE; run=1, tick_en every cycle -> pwm_out repeats 1,1,0,0,0; period_done pulses every 5 cycles; cnt 0..4 wraps.
- Tick gating: tick_en every 3rd cycle, period=1, duty=1 -> each pwm_out level holds 3 cycles; cnt changes only after tick cycles.
- Shadow update: running period=4, duty=2; offer period=2, duty=3 at cnt=1 -> cfg_ready drops next cycle. The current period completes as 1,1,0,0,0, then 1,1,1 repeating (duty>period gives constant high). cfg_ready returns to 1 after the boundary.
- Stop/resume: deassert run at cnt=2 -> period finishes, boundary to IDLE, pwm_out=0, period_done one final pulse. A separate run drops at cnt=1 and re-asserts at cnt=3 -> no break in the 0..4 sequence.
- Edge values: duty=0 -> pwm_out constant 0. Period=0, duty=1 -> pwm_out constant 1 with period_done every tick. Offer config on the boundary edge -> applied one period later.
